// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the lcd_text_ctrl slice.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h28;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  localparam int unsigned INIT_STEPS = 8;

  typedef enum logic [2:0] {
    ST_PWR_WAIT, ST_INIT, ST_IDLE, ST_ROW_ADDR, ST_CHAR, ST_DONE
  } top_state_e;

  typedef enum logic [1:0] {NB_IDLE, NB_SETUP, NB_EHIGH, NB_ELOW} nib_state_e;

  typedef enum logic [1:0] {PH_HI, PH_LO, PH_WAIT} xfer_phase_e;

  typedef struct packed {
    logic       is_byte;
    logic       long_wait;
    logic [7:0] data;
  } init_step_t;

  // The first four steps are lone nibbles taken from data[3:0].
  function automatic init_step_t init_step(input logic [2:0] idx);
    init_step_t s;
    s = '{is_byte: 1'b1, long_wait: 1'b0, data: 8'h00};
    case (idx)
      3'd0: s = '{is_byte: 1'b0, long_wait: 1'b1, data: 8'h03};
      3'd1: s = '{is_byte: 1'b0, long_wait: 1'b0, data: 8'h03};
      3'd2: s = '{is_byte: 1'b0, long_wait: 1'b0, data: 8'h03};
      3'd3: s = '{is_byte: 1'b0, long_wait: 1'b0, data: 8'h02};
      3'd4: s.data = FUNC_SET;
      3'd5: s.data = DISP_ON;
      3'd6: s.data = ENTRY;
      default: begin
        s.data      = CLEAR;
        s.long_wait = 1'b1;
      end
    endcase
    return s;
  endfunction

  function automatic logic [6:0] row_base(input logic [1:0] row, input int unsigned cols);
    case (row)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return 7'(cols);
      default: return 7'(7'h40 + cols);
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// Text-source and LCD-pin signals of lcd_text_ctrl; master is the controller side.
interface lcd_text_ctrl_if #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 16
);
  logic [8*ROWS*COLS-1:0] strdata;
  logic                   refresh;
  logic                   busy;
  logic                   frame_done;
  logic                   rslcd;
  logic                   rwlcd;
  logic                   elcd;
  logic [3:0]             lcdd;

  modport master (
    input  strdata, refresh,
    output busy, frame_done, rslcd, rwlcd, elcd, lcdd
  );

  modport slave (
    output strdata, refresh,
    input  busy, frame_done, rslcd, rwlcd, elcd, lcdd
  );
endinterface

// File: rtl/lcd_nibble_tx.sv
// One 4-bit bus write: SETUP (1 cycle), E high for E_CYCLES, E low for E_CYCLES, then a done pulse.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned E_CYCLES = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       rs_i,
  input  logic [3:0] nib_i,
  output logic       done_o,
  output logic       e_o,
  output logic       rs_o,
  output logic [3:0] d_o
);
  localparam int unsigned     E_W    = $clog2(E_CYCLES + 1);
  localparam logic [E_W-1:0]  E_LAST = E_W'(E_CYCLES - 1);

  nib_state_e     state_q, state_d;
  logic [E_W-1:0] cnt_q, cnt_d;
  logic           e_q, done_q, rs_q;
  logic [3:0]     d_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      NB_IDLE:  if (req_i) state_d = NB_SETUP;
      NB_SETUP: begin
        state_d = NB_EHIGH;
        cnt_d   = '0;
      end
      NB_EHIGH: begin
        if (cnt_q == E_LAST) begin
          state_d = NB_ELOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == E_LAST) state_d = NB_IDLE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
    endcase
  end

  // E is registered off the next state so it tracks state_q with no decode glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= NB_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= (state_d == NB_EHIGH);
      done_q  <= (state_q == NB_ELOW) && (state_d == NB_IDLE);
      if (state_q == NB_IDLE && req_i) begin
        rs_q <= rs_i;
        d_q  <= nib_i;
      end
    end
  end

  assign done_o = done_q;
  assign e_o    = e_q;
  assign rs_o   = rs_q;
  assign d_o    = d_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 4-bit text controller: power-up init, then snapshotted ROWS x COLS frame copies.
// Optional LCD_CHANGE_DETECT_EN skips frames whose text equals the last frame written.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned COLS              = 16,
  parameter int unsigned ROWS              = 2,
  parameter int unsigned AUTO_REFRESH      = 1,
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned E_CYCLES          = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input logic             CCLK,
  input logic             reset,
  lcd_text_ctrl_if.master lcd
);
  localparam int unsigned NB     = 8 * ROWS * COLS;
  localparam int unsigned MAXW_A = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAXW   = (MAXW_A > CMD_WAIT_CYCLES) ? MAXW_A : CMD_WAIT_CYCLES;
  localparam int unsigned W_W    = $clog2(MAXW + 1);
  localparam int unsigned COL_W  = $clog2(COLS);

  localparam logic [W_W-1:0]   PWR_LAST = W_W'(POWERUP_CYCLES - 1);
  localparam logic [W_W-1:0]   CMD_LAST = W_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [W_W-1:0]   CLR_LAST = W_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [1:0]       LAST_ROW = 2'(ROWS - 1);
  localparam logic             AUTO     = (AUTO_REFRESH != 0);

  top_state_e       state_q, state_d;
  xfer_phase_e      ph_q, ph_d;
  logic             sent_q, sent_d;
  logic [W_W-1:0]   cnt_q, cnt_d;
  logic [2:0]       init_q, init_d;
  logic [1:0]       row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [NB-1:0]    snap_q, snap_d;
  logic             pend_q, pend_d;
  logic             fd_q;

  init_step_t     ist;
  logic [7:0]     cur_byte;
  logic           cur_single, cur_long, step_done;
  logic [W_W-1:0] wait_last;
  logic           tx_req, tx_rs, tx_done;
  logic [3:0]     tx_nib;
  logic           start_req, skip, frame_go;

  assign ist       = init_step(init_q);
  assign start_req = AUTO | pend_q | lcd.refresh;
  assign frame_go  = (state_q == ST_IDLE) && start_req && !skip;

`ifdef LCD_CHANGE_DETECT_EN
  logic [NB-1:0] last_q;
  logic          last_vld_q;

  assign skip = last_vld_q && (lcd.strdata == last_q);

  always_ff @(posedge CCLK) begin
    if (reset) begin
      last_vld_q <= 1'b0;
      last_q     <= '0;
    end else if (frame_go) begin
      last_vld_q <= 1'b1;
      last_q     <= lcd.strdata;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    sent_d     = sent_q;
    cnt_d      = cnt_q;
    init_d     = init_q;
    row_d      = row_q;
    col_d      = col_q;
    snap_d     = snap_q;
    pend_d     = pend_q | (lcd.refresh & ~AUTO);
    tx_req     = 1'b0;
    step_done  = 1'b0;
    cur_byte   = 8'h00;
    cur_single = 1'b0;
    cur_long   = 1'b0;

    case (state_q)
      ST_INIT: begin
        cur_byte   = ist.data;
        cur_single = ~ist.is_byte;
        cur_long   = ist.long_wait;
      end
      ST_ROW_ADDR: cur_byte = SET_DDRAM | {1'b0, row_base(row_q, COLS)};
      ST_CHAR:     cur_byte = snap_q[NB-1 -: 8];
      default: ;
    endcase

    tx_rs     = (state_q == ST_CHAR);
    tx_nib    = (ph_q == PH_LO || cur_single) ? cur_byte[3:0] : cur_byte[7:4];
    wait_last = cur_long ? CLR_LAST : CMD_LAST;

    // Shared byte sequencer: high nibble, low nibble (skipped for lone nibbles), post-wait.
    if (state_q inside {ST_INIT, ST_ROW_ADDR, ST_CHAR}) begin
      case (ph_q)
        PH_HI, PH_LO: begin
          tx_req = ~sent_q;
          sent_d = 1'b1;
          if (tx_done) begin
            sent_d = 1'b0;
            cnt_d  = '0;
            ph_d   = (ph_q == PH_HI && !cur_single) ? PH_LO : PH_WAIT;
          end
        end
        default: begin
          if (cnt_q == wait_last) begin
            cnt_d     = '0;
            ph_d      = PH_HI;
            step_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          ph_d    = PH_HI;
          init_d  = '0;
          state_d = ST_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (step_done) begin
          if (init_q == 3'(INIT_STEPS - 1)) state_d = ST_IDLE;
          else                              init_d  = init_q + 3'd1;
        end
      end
      ST_IDLE: begin
        if (start_req) pend_d = 1'b0;
        if (frame_go) begin
          state_d = ST_ROW_ADDR;
          snap_d  = lcd.strdata;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_ROW_ADDR: if (step_done) state_d = ST_CHAR;
      ST_CHAR: begin
        if (step_done) begin
          snap_d = {snap_q[NB-9:0], 8'h00};
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + 2'd1;
              state_d = ST_ROW_ADDR;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      state_q <= ST_PWR_WAIT;
      ph_q    <= PH_HI;
      sent_q  <= 1'b0;
      cnt_q   <= '0;
      init_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      row_q   <= row_d;
      col_q   <= col_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      fd_q    <= (state_d == ST_DONE);
    end
  end

  lcd_nibble_tx #(.E_CYCLES(E_CYCLES)) u_tx (
    .clk_i  (CCLK),
    .rst_i  (reset),
    .req_i  (tx_req),
    .rs_i   (tx_rs),
    .nib_i  (tx_nib),
    .done_o (tx_done),
    .e_o    (lcd.elcd),
    .rs_o   (lcd.rslcd),
    .d_o    (lcd.lcdd)
  );

  assign lcd.busy       = (state_q != ST_IDLE) || frame_go;
  assign lcd.frame_done = fd_q;
  assign lcd.rwlcd      = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl: a 2x16 on-request instance and a 4x20 auto-refresh instance.
module tb_lcd_text_ctrl;
  localparam int unsigned PW = 20, EC = 2, CW = 5, CL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  lcd_text_ctrl_if #(.ROWS(2), .COLS(16)) ifa ();
  lcd_text_ctrl_if #(.ROWS(4), .COLS(20)) ifb ();

  lcd_text_ctrl #(
    .COLS(16), .ROWS(2), .AUTO_REFRESH(0), .POWERUP_CYCLES(PW), .E_CYCLES(EC),
    .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CL)
  ) dut_a (.CCLK(clk), .reset(rst_a), .lcd(ifa.master));

  lcd_text_ctrl #(
    .COLS(20), .ROWS(4), .AUTO_REFRESH(1), .POWERUP_CYCLES(PW), .E_CYCLES(EC),
    .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CL)
  ) dut_b (.CCLK(clk), .reset(rst_b), .lcd(ifb.master));

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitors: one {rs, nibble} entry per rising edge of E.
  logic [4:0]  qa[$], qb[$], exp_q[$];
  int unsigned rise_a[$], fall_a[$];
  logic        ea_prev = 1'b0, eb_prev = 1'b0, fda_prev = 1'b0;
  int unsigned fd_a = 0, fd_a_hi = 0, fd_b = 0;

  always @(negedge clk) begin
    if (ifa.elcd && !ea_prev) begin
      qa.push_back({ifa.rslcd, ifa.lcdd});
      rise_a.push_back(cyc);
    end
    if (!ifa.elcd && ea_prev) fall_a.push_back(cyc);
    ea_prev = ifa.elcd;
    if (ifa.frame_done) fd_a_hi++;
    if (ifa.frame_done && !fda_prev) fd_a++;
    fda_prev = ifa.frame_done;
    if (ifb.elcd && !eb_prev && fd_b == 0) qb.push_back({ifb.rslcd, ifb.lcdd});
    eb_prev = ifb.elcd;
    if (ifb.frame_done) fd_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03); exp_q.push_back(5'h03);
    exp_q.push_back(5'h03); exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06); push_byte(1'b0, 8'h01);
  endtask

  task automatic push_frame16(input logic [7:0] c0, input logic [7:0] crest);
    for (int r = 0; r < 2; r++) begin
      push_byte(1'b0, (r == 0) ? 8'h80 : 8'hC0);
      for (int c = 0; c < 16; c++) push_byte(1'b1, (r == 0 && c == 0) ? c0 : crest);
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, qa.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < qa.size(); i++)
      check($sformatf("%s[%0d]", tag, i), qa[i], exp_q[i]);
  endtask

  task automatic clear_a();
    qa.delete(); rise_a.delete(); fall_a.delete(); exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int unsigned lim);
    int unsigned n = 0;
    @(negedge clk);
    while (ifa.busy !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    check(tag, ifa.busy, 0);
  endtask

  task automatic wait_fd(input string tag, input int unsigned target, input int unsigned lim);
    int unsigned n = 0;
    while (fd_a < target && n < lim) begin @(negedge clk); n++; end
    check(tag, fd_a, target);
  endtask

  task automatic pulse_refresh();
    @(negedge clk); ifa.refresh = 1'b1;
    @(negedge clk); ifa.refresh = 1'b0;
  endtask

  logic [7:0]  b_addr [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
  int unsigned fd0, hi0, idle_cyc, n;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.refresh = 1'b0; ifb.refresh = 1'b0;
    ifa.strdata = {8'h41, {31{8'h20}}};
    ifb.strdata = {80{8'h20}};
    repeat (3) @(negedge clk);
    check("rst_elcd", ifa.elcd, 0);
    check("rst_rslcd", ifa.rslcd, 0);
    check("rst_rwlcd", ifa.rwlcd, 0);
    check("rst_lcdd", ifa.lcdd, 0);
    check("rst_busy", ifa.busy, 1);
    check("rst_frame_done", ifa.frame_done, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    wait_idle("init_idle", 3000);
    idle_cyc = cyc;
    push_init();
    compare_stream("init");
    check("gap_first_nibble", (rise_a.size() > 1) ? (rise_a[1] - fall_a[0] >= 10) : 1'b0, 1);
    check("gap_after_clear", (fall_a.size() >= 12) ? (idle_cyc - fall_a[11] >= 10) : 1'b0, 1);

    clear_a(); fd0 = fd_a; hi0 = fd_a_hi;
    pulse_refresh();
    check("busy_in_frame", ifa.busy, 1);
    wait_fd("frame1_done", fd0 + 1, 5000);
    repeat (3) @(negedge clk);
    check("frame_done_width", fd_a_hi - hi0, 1);
    check("busy_after_frame1", ifa.busy, 0);
    push_frame16(8'h41, 8'h20);
    compare_stream("frame1");

    // New text mid-frame plus two merged requests: old-snapshot frame, then exactly one new frame.
    clear_a(); fd0 = fd_a;
    ifa.strdata = {32{8'h41}};
    pulse_refresh();
    n = 0;
    while (qa.size() < 20 && n < 2000) begin @(negedge clk); n++; end
    ifa.strdata = {32{8'h5A}};
    pulse_refresh();
    repeat (10) @(negedge clk);
    pulse_refresh();
    wait_fd("two_frames_done", fd0 + 2, 8000);
    repeat (300) @(negedge clk);
    check("merged_frame_count", fd_a - fd0, 2);
    check("idle_after_merge", ifa.busy, 0);
    push_frame16(8'h41, 8'h41);
    push_frame16(8'h5A, 8'h5A);
    compare_stream("snapshot_merge");

    clear_a(); fd0 = fd_a;
    pulse_refresh();
    n = 0;
    while (!(ifa.elcd === 1'b1 && qa.size() >= 6) && n < 3000) begin @(negedge clk); n++; end
    check("elcd_high_before_reset", ifa.elcd, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("reset_elcd_drop", ifa.elcd, 0);
    check("reset_busy", ifa.busy, 1);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    clear_a();
    wait_idle("reinit_idle", 3000);
    push_init();
    compare_stream("reinit");
    check("no_done_on_abort", fd_a - fd0, 0);

    clear_a(); fd0 = fd_a;
    pulse_refresh();
    wait_fd("post_reset_frame", fd0 + 1, 5000);
    repeat (3) @(negedge clk);
    push_frame16(8'h5A, 8'h5A);
    compare_stream("post_reset");

    clear_a(); fd0 = fd_a;
`ifdef LCD_CHANGE_DETECT_EN
    @(negedge clk); ifa.refresh = 1'b1;
    #1 check("cd_busy_on_request", ifa.busy, 0);
    @(negedge clk); ifa.refresh = 1'b0;
    repeat (300) @(negedge clk);
    check("cd_no_nibbles", qa.size(), 0);
    check("cd_no_done", fd_a - fd0, 0);
    check("cd_busy_idle", ifa.busy, 0);
`else
    pulse_refresh();
    wait_fd("repeat_frame", fd0 + 1, 5000);
    repeat (3) @(negedge clk);
    push_frame16(8'h5A, 8'h5A);
    compare_stream("repeat");
`endif

    n = 0;
    while (fd_b == 0 && n < 10000) begin @(negedge clk); n++; end
    check("b_frame_done", fd_b > 0, 1);
    check("b_nibble_count", qb.size(), 180);
    if (qb.size() >= 180)
      for (int r = 0; r < 4; r++)
        check($sformatf("b_row%0d_addr", r), {qb[12 + 42*r], qb[13 + 42*r]},
              {1'b0, b_addr[r][7:4], 1'b0, b_addr[r][3:0]});
`ifndef LCD_CHANGE_DETECT_EN
    check("b_busy_auto", ifb.busy, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
